fifo_axis_packer: RTL and testbench

//  Read-side consumer of the async count FIFO: pops narrow words in the FIFO read clock domain,

---
 rtl/fifo_axis_packer_if.sv | 27 ++
 rtl/fifo_axis_packer.sv | 170 +++++++++++++++++
 tb/tb_fifo_axis_packer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_axis_packer_if.sv
// AXI-Stream beat bus between the packer (master) and downstream logic (slave).
interface fifo_axis_packer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PACK_RATIO = 4
);
    logic [DATA_WIDTH*PACK_RATIO-1:0] tdata;
    logic [PACK_RATIO-1:0]            tkeep;
    logic                             tlast;
    logic                             tvalid;
    logic                             tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/fifo_axis_packer.sv
// Pops narrow FWFT FIFO words, packs PACK_RATIO of them per AXI-Stream beat,
// tags tlast every pkt_len beats and closes partial beats on flush.
module fifo_axis_packer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned PACK_RATIO    = 4,
    parameter int unsigned PKT_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [PKT_LEN_WIDTH-1:0] pkt_len,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    fifo_axis_packer_if.master       m_axis,
    output logic                     busy
);
    localparam int unsigned BEAT_W = DATA_WIDTH * PACK_RATIO;
    localparam int unsigned LANE_W = $clog2(PACK_RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);

    typedef enum logic {
        ST_PACK  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                   state_q,    state_d;
    logic [LANE_W-1:0]        lane_cnt_q, lane_cnt_d;
    logic [BEAT_W-1:0]        pack_q,     pack_d;
    logic [PKT_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [PKT_LEN_WIDTH-1:0] eff_len_q,  eff_len_d;
    logic [BEAT_W-1:0]        tdata_q,    tdata_d;
    logic [PACK_RATIO-1:0]    tkeep_q,    tkeep_d;
    logic                     tlast_q,    tlast_d;
    logic                     tvalid_q,   tvalid_d;

    logic                     out_free;
    logic                     pop;
    logic                     load_beat;
    logic                     flush_beat;
    logic [BEAT_W-1:0]        load_data;
    logic [PACK_RATIO-1:0]    load_keep;
    logic [PKT_LEN_WIDTH-1:0] cur_len;

    // State and datapath registers; reset discards any partial beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PACK;
            lane_cnt_q <= '0;
            pack_q     <= '0;
            beat_cnt_q <= '0;
            eff_len_q  <= '0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            pack_q     <= pack_d;
            beat_cnt_q <= beat_cnt_d;
            eff_len_q  <= eff_len_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    // Pop decision, lane packing, flush handling and output beat loading.
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        pack_d     = pack_q;
        beat_cnt_d = beat_cnt_q;
        eff_len_d  = eff_len_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        load_beat  = 1'b0;
        flush_beat = 1'b0;
        load_data  = '0;
        load_keep  = '0;

        out_free = ~tvalid_q | m_axis.tready;
        // The final lane may only pop when the output register can take the beat.
        pop = rst_n & enable & ~flush & (state_q == ST_PACK) & ~fifo_empty &
              ((lane_cnt_q != LAST_LANE) | out_free);

        if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_PACK: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (pop) begin
                    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                        if (lane_cnt_q == LANE_W'(i)) begin
                            pack_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                        end
                    end
                    if (lane_cnt_q == LAST_LANE) begin
                        load_beat  = 1'b1;
                        load_data  = pack_d;
                        load_keep  = '1;
                        lane_cnt_d = '0;
                        pack_d     = '0;
                    end else begin
                        lane_cnt_d = lane_cnt_q + LANE_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (lane_cnt_q == '0) begin
                    beat_cnt_d = '0;
                    state_d    = ST_PACK;
                end else if (out_free) begin
                    load_beat  = 1'b1;
                    flush_beat = 1'b1;
                    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                        if (i < 32'(lane_cnt_q)) begin
                            load_data[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i*DATA_WIDTH +: DATA_WIDTH];
                            load_keep[i] = 1'b1;
                        end
                    end
                    lane_cnt_d = '0;
                    pack_d     = '0;
                    state_d    = ST_PACK;
                end
            end
            default: state_d = ST_PACK;
        endcase

        // Packet length is latched with the first beat of each packet.
        if (beat_cnt_q == '0) begin
            cur_len = (pkt_len == '0) ? PKT_LEN_WIDTH'(1) : pkt_len;
        end else begin
            cur_len = eff_len_q;
        end

        if (load_beat) begin
            tdata_d  = load_data;
            tkeep_d  = load_keep;
            tvalid_d = 1'b1;
            if (flush_beat) begin
                tlast_d    = 1'b1;
                beat_cnt_d = '0;
            end else begin
                tlast_d = (beat_cnt_q == cur_len - PKT_LEN_WIDTH'(1));
                if (beat_cnt_q == '0) begin
                    eff_len_d = cur_len;
                end
                beat_cnt_d = tlast_d ? '0 : beat_cnt_q + PKT_LEN_WIDTH'(1);
            end
        end
    end

    // Output drive.
    assign fifo_rd_en    = pop;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;
    assign busy          = (lane_cnt_q != '0) | tvalid_q | (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Self-checking bench: FWFT FIFO model, beat scoreboard, vector table and corner sequences.
module tb_fifo_axis_packer;
    localparam int unsigned DW = 16;
    localparam int unsigned PR = 4;
    localparam int unsigned PW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [PW-1:0] pkt_len;
    logic          flush;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          busy;

    fifo_axis_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) m_axis ();

    fifo_axis_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .PKT_LEN_WIDTH(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pkt_len      (pkt_len),
        .flush        (flush),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_axis       (m_axis),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [PW-1:0] pkt_len;
        int            nwords;
        logic [15:0]   base;
        int            exp_beats;
        int            exp_lasts;
        logic [63:0]   exp_last_data;
    } vec_t;

    logic [15:0] fifo_q[$];
    beat_t       exp_q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int beats_seen = 0;
    int lasts_seen = 0;
    logic [63:0] last_data = '0;
    logic [3:0]  last_keep = '0;
    logic        last_last = 1'b0;

    // Reference packing model state
    logic [63:0] model_data = '0;
    int          model_lane = 0;
    int          model_beat = 0;
    int          model_len = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic refresh_fifo();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? 16'h0 : fifo_q[0];
    endtask

    task automatic model_word(input logic [15:0] w);
        logic lst;
        model_data[model_lane*16 +: 16] = w;
        model_lane++;
        if (model_lane == 4) begin
            if (model_beat == 0) model_len = (pkt_len == 0) ? 1 : int'(pkt_len);
            lst = (model_beat == model_len - 1);
            exp_q.push_back('{data: model_data, keep: 4'hF, last: lst});
            model_beat = lst ? 0 : model_beat + 1;
            model_lane = 0;
            model_data = '0;
        end
    endtask

    task automatic model_flush();
        logic [3:0] k;
        if (model_lane > 0) begin
            k = 4'((1 << model_lane) - 1);
            exp_q.push_back('{data: model_data, keep: k, last: 1'b1});
        end
        model_lane = 0;
        model_data = '0;
        model_beat = 0;
    endtask

    task automatic model_reset();
        model_lane = 0;
        model_data = '0;
        model_beat = 0;
        exp_q.delete();
    endtask

    task automatic push_words(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 16'(i));
            model_word(base + 16'(i));
        end
        refresh_fifo();
    endtask

    // One clock: observe pop/handshake at negedge, update FIFO head after the edge.
    task automatic cycle();
        beat_t e;
        @(negedge clk);
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                fail_now("pop_on_empty");
            end else begin
                void'(fifo_q.pop_front());
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
        if (m_axis.tvalid && m_axis.tready) begin
            beats_seen++;
            if (m_axis.tlast) lasts_seen++;
            last_data = m_axis.tdata;
            last_keep = m_axis.tkeep;
            last_last = m_axis.tlast;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = exp_q.pop_front();
                chk("beat_tdata", m_axis.tdata, e.data);
                chk("beat_tkeep", 64'(m_axis.tkeep), 64'(e.keep));
                chk("beat_tlast", 64'(m_axis.tlast), 64'(e.last));
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        refresh_fifo();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_axis.tvalid) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) fail_now("drain_timeout");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int b0, l0, n;
        logic [63:0] held;

        vecs[0] = '{16'd2, 8,  16'h0001, 2, 1, 64'h0008_0007_0006_0005};
        vecs[1] = '{16'd0, 12, 16'h0100, 3, 3, 64'h010B_010A_0109_0108};
        vecs[2] = '{16'd1, 8,  16'h0040, 2, 2, 64'h0047_0046_0045_0044};
        vecs[3] = '{16'd3, 24, 16'h1000, 6, 2, 64'h1017_1016_1015_1014};

        // Reset with a non-empty FIFO
        rst_n        = 1'b0;
        enable       = 1'b1;
        pkt_len      = 16'd2;
        flush        = 1'b0;
        fifo_empty   = 1'b0;
        fifo_rd_data = 16'hDEAD;
        m_axis.tready = 1'b1;
        #12;
        chk("rst_rd_en",  64'(fifo_rd_en), 64'd0);
        chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("rst_tdata",  m_axis.tdata, 64'd0);
        chk("rst_tkeep",  64'(m_axis.tkeep), 64'd0);
        chk("rst_tlast",  64'(m_axis.tlast), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        refresh_fifo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven packets with tready=1 and a pre-filled FIFO
        for (int v = 0; v < 4; v++) begin
            pkt_len   = vecs[v].pkt_len;
            b0        = beats_seen;
            l0        = lasts_seen;
            pops      = 0;
            first_pop = -1;
            push_words(vecs[v].nwords, vecs[v].base);
            drain(200);
            chk($sformatf("vec%0d_beats", v), 64'(beats_seen - b0), 64'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_lasts", v), 64'(lasts_seen - l0), 64'(vecs[v].exp_lasts));
            chk($sformatf("vec%0d_pops", v),  64'(pops), 64'(vecs[v].nwords));
            chk($sformatf("vec%0d_span", v),  64'(last_pop - first_pop + 1), 64'(vecs[v].nwords));
            chk($sformatf("vec%0d_lastdata", v), last_data, vecs[v].exp_last_data);
        end

        // Backpressure: output stalls, exactly 3 more pops, then no popping
        pkt_len       = 16'd2;
        m_axis.tready = 1'b0;
        pops          = 0;
        push_words(16, 16'h0200);
        n = 0;
        while (!m_axis.tvalid && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) fail_now("bp_wait_tvalid");
        held = m_axis.tdata;
        chk("bp_held_data", held, 64'h0203_0202_0201_0200);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("bp_tdata_stable", m_axis.tdata, held);
        end
        chk("bp_pops", 64'(pops), 64'd7);
        chk("bp_rd_en_low", 64'(fifo_rd_en), 64'd0);
        m_axis.tready = 1'b1;
        drain(200);
        chk("bp_all_popped", 64'(pops), 64'd16);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush closes a two-lane partial beat
        pkt_len = 16'd4;
        pops    = 0;
        push_words(2, 16'h000A);
        for (int k = 0; k < 4; k++) cycle();
        chk("fl_pops", 64'(pops), 64'd2);
        model_flush();
        flush = 1'b1;
        cycle();
        chk("fl_busy", 64'(busy), 64'd1);
        drain(50);
        chk("fl_data", last_data, 64'h0000_0000_000B_000A);
        chk("fl_keep", 64'(last_keep), 64'h3);
        chk("fl_last", 64'(last_last), 64'd1);
        pkt_len = 16'd2;
        l0      = lasts_seen;
        push_words(8, 16'h0300);
        drain(100);
        chk("fl_next_pkt_lasts", 64'(lasts_seen - l0), 64'd1);

        // pkt_len change mid-packet takes effect only at the next packet
        pkt_len = 16'd3;
        push_words(4, 16'h0400);
        drain(50);
        pkt_len = 16'd1;
        b0      = beats_seen;
        l0      = lasts_seen;
        push_words(16, 16'h0500);
        drain(100);
        chk("len_chg_beats", 64'(beats_seen - b0), 64'd4);
        chk("len_chg_lasts", 64'(lasts_seen - l0), 64'd3);

        // Async reset with a held beat and two partial lanes
        pkt_len       = 16'd4;
        m_axis.tready = 1'b0;
        pops          = 0;
        push_words(6, 16'h0030);
        for (int k = 0; k < 8; k++) cycle();
        chk("mr_pops", 64'(pops), 64'd6);
        chk("mr_tvalid_pre", 64'(m_axis.tvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("mr_tdata",  m_axis.tdata, 64'd0);
        chk("mr_tkeep",  64'(m_axis.tkeep), 64'd0);
        chk("mr_tlast",  64'(m_axis.tlast), 64'd0);
        chk("mr_busy",   64'(busy), 64'd0);
        model_reset();
        fifo_q.delete();
        refresh_fifo();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        m_axis.tready = 1'b1;
        push_words(4, 16'h0011);
        drain(50);
        chk("mr_after_data", last_data, 64'h0014_0013_0012_0011);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
